ddr3_cache_ctrl: RTL and testbench
==================================

Name: ddr3_cache_ctrl

Overview:
Direct-mapped, write-back, write-allocate cache between a 32-bit word-access bus and a DDR3 memory controller with a 256-bit line interface. Bus hits complete locally. Misses write back the dirty victim line, then fill the line from DDR3 over a strobe/ack handshake. A debug state word is exported.

Parameters:
INDEX_BITS, 6, number of index bits; the cache holds 2^INDEX_BITS lines of 32 bytes each (default 2 KiB).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-low reset.
addr_i  in  32  bus byte address; bits [1:0] are ignored.
data_i  in  32  bus write data.
data_o  out  32  bus read data; valid while ack_o=1 for a read, held afterwards.
we_i  in  1  write request level; held until ack_o.
rd_i  in  1  read request level; held until ack_o.
ack_o  out  1  one-cycle pulse marking request completion.
ctrl_addr_i  out  29  DDR line address = {addr[31:5], 2'b00}, in 8-byte units.
ctrl_data_i  out  256  line data sent to DDR for a writeback; word w sits at bits [32w+31:32w].
ctrl_data_o  in  256  line data returned by DDR on a fill.
ctrl_we_i  out  1  DDR write strobe.
ctrl_rd_i  out  1  DDR read strobe.
ctrl_ack_o  in  1  DDR completion; may stay high for more than one cycle.
state_value  out  16  debug word: {12'b0, state[3:0]}.

Behaviour:
- Address split: word offset = addr[4:2]; index = addr[4+INDEX_BITS:5]; tag = addr[31:5+INDEX_BITS].
- Per line storage: 256-bit data, tag, valid bit, dirty bit.
- Reset (rst=0, asynchronous):
  - All valid and dirty bits cleared.
  - ack_o, ctrl_we_i, ctrl_rd_i, data_o, ctrl_addr_i and ctrl_data_i all 0.
  - State = INIT. Reset in mid-operation aborts immediately and drops the strobes.
- State codes: INIT=0, IDLE=1, COMPARE=2, WB=3, WB_REL=4, FILL=5, FILL_REL=6, DONE=7.
- INIT: wait for ctrl_ack_o=1 (DDR calibration done), then wait for ctrl_ack_o=0, then go to IDLE. Bus requests are not acknowledged in this state.
- IDLE: on we_i or rd_i, latch the address, data and operation, then go to COMPARE. Write has priority if both are high.
- COMPARE, hit (valid and tag match):
  - Write: update the addressed word and set dirty.
  - Read: load data_o from the addressed word.
  - Pulse ack_o for one cycle and go to DONE.
  - A hit therefore acks on the 2nd clock after the request is first sampled.
- COMPARE, miss:
  - Victim valid and dirty: go to WB with ctrl_addr_i = victim {tag, index, 2'b00} and ctrl_data_i = victim line.
  - Otherwise: go to FILL with ctrl_addr_i = request line address.
- WB: hold ctrl_we_i=1 until ctrl_ack_o is sampled high. Then drop ctrl_we_i, clear dirty and go to WB_REL.
- WB_REL: wait for ctrl_ack_o=0, then go to FILL with ctrl_addr_i = request line address.
- FILL: hold ctrl_rd_i=1 until ctrl_ack_o is sampled high. On that edge, capture ctrl_data_o into the line, write the tag, set valid, clear dirty, drop ctrl_rd_i and go to FILL_REL.
- FILL_REL: wait for ctrl_ack_o=0, then go to COMPARE. The retried lookup now hits and completes normally.
- DONE: wait until we_i=0 and rd_i=0, then go to IDLE. A held request is never executed twice.
- Strobe rules:
  - ctrl_we_i and ctrl_rd_i are never high together.
  - Each DDR command is a fresh rising edge of its strobe.
  - ctrl_addr_i and ctrl_data_i are stable while a strobe is high.
- Requests are never lost. If the bus drops a request before ack, behaviour is undefined; the bus is required to hold requests.
- Unused bits of state_value read as 0.

Test Plan:
- Reset low, then high; raise we_i before any ctrl_ack_o pulse -> ack_o stays 0 and state_value=0. Pulse ctrl_ack_o for one cycle -> state_value=1.
- After init, write 0x00000000=0x01234567 -> ctrl_rd_i rises with ctrl_addr_i=0. Return a zero line with ack -> ack_o pulses once and state ends at DONE (7).
- Read 0x00000000 -> hit: ack_o on the 2nd clock, data_o=0x01234567, no DDR strobes.
- Write 0x00000004=0x01020304, then read 0x00000004 -> both hit; data_o=0x01020304.
- Read 0x00100000 (same index, new tag):
  - ctrl_we_i first, with ctrl_addr_i=0 and ctrl_data_i[63:0]=0x01020304_01234567, upper bits 0.
  - Then, after ack release, ctrl_rd_i with ctrl_addr_i=0x0020000.
  - Fill with zeros -> data_o=0 and ack_o pulses once.
- Hold rd_i through ack for 3 cycles -> exactly one ack_o pulse. Assert reset during FILL -> ctrl_rd_i drops immediately and state_value=0.

Source files
------------

// File: rtl/ddr3_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache between a 32-bit word bus
// and a DDR3 controller that transfers 256-bit lines over a strobe/ack handshake.
module ddr3_cache_ctrl #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  data_i,
    output logic [31:0]  data_o,
    input  logic         we_i,
    input  logic         rd_i,
    output logic         ack_o,
    output logic [28:0]  ctrl_addr_i,
    output logic [255:0] ctrl_data_i,
    input  logic [255:0] ctrl_data_o,
    output logic         ctrl_we_i,
    output logic         ctrl_rd_i,
    input  logic         ctrl_ack_o,
    output logic [15:0]  state_value
);

    localparam int unsigned LINES     = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS  = 27 - INDEX_BITS;
    localparam int unsigned LINE_BITS = 256;
    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        IDLE     = 4'd1,
        COMPARE  = 4'd2,
        WB       = 4'd3,
        WB_REL   = 4'd4,
        FILL     = 4'd5,
        FILL_REL = 4'd6,
        DONE     = 4'd7
    } state_t;

    state_t state_q, state_d;
    logic   init_seen_q, init_seen_d;

    // Latched bus request
    logic [31:2]          req_addr_q;
    logic [WORD_BITS-1:0] req_data_q;
    logic                 req_we_q;

    // Line storage
    logic [LINE_BITS-1:0] line_mem [LINES];
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;

    // Next values of registered outputs
    logic                 ack_d;
    logic [WORD_BITS-1:0] data_o_d;
    logic [28:0]          ctrl_addr_d;
    logic [LINE_BITS-1:0] ctrl_data_d;
    logic                 ctrl_we_d;
    logic                 ctrl_rd_d;

    // Storage update controls
    logic                 latch_c;
    logic                 line_we_c;
    logic [LINE_BITS-1:0] line_wdata_c;
    logic                 tag_we_c;
    logic                 valid_set_c;
    logic                 dirty_set_c;
    logic                 dirty_clr_c;

    logic [2:0]            req_off_c;
    logic [INDEX_BITS-1:0] req_idx_c;
    logic [TAG_BITS-1:0]   req_tag_c;
    logic [LINE_BITS-1:0]  cur_line_c;
    logic [TAG_BITS-1:0]   cur_tag_c;
    logic                  hit_c;
    logic                  unused_addr_c;

    // Byte-lane bits of the bus address carry no information for word access
    assign unused_addr_c = ^addr_i[1:0];

    // Address split of the latched request and lookup of its line
    assign req_off_c  = req_addr_q[4:2];
    assign req_idx_c  = req_addr_q[4+INDEX_BITS:5];
    assign req_tag_c  = req_addr_q[31:5+INDEX_BITS];
    assign cur_line_c = line_mem[req_idx_c];
    assign cur_tag_c  = tag_mem[req_idx_c];
    assign hit_c      = valid_q[req_idx_c] && (cur_tag_c == req_tag_c);

    assign state_value = {12'd0, 4'(state_q)};

    // Next-state, registered-output next values and storage update controls
    always_comb begin
        state_d      = state_q;
        init_seen_d  = init_seen_q;
        ack_d        = 1'b0;
        data_o_d     = data_o;
        ctrl_addr_d  = ctrl_addr_i;
        ctrl_data_d  = ctrl_data_i;
        ctrl_we_d    = 1'b0;
        ctrl_rd_d    = 1'b0;
        latch_c      = 1'b0;
        line_we_c    = 1'b0;
        line_wdata_c = cur_line_c;
        tag_we_c     = 1'b0;
        valid_set_c  = 1'b0;
        dirty_set_c  = 1'b0;
        dirty_clr_c  = 1'b0;

        case (state_q)
            INIT: begin
                // DDR calibration: one full high-then-low cycle of ctrl_ack_o
                if (ctrl_ack_o) begin
                    init_seen_d = 1'b1;
                end else if (init_seen_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (we_i || rd_i) begin
                    latch_c = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit_c) begin
                    if (req_we_q) begin
                        line_wdata_c[{req_off_c, 5'd0} +: WORD_BITS] = req_data_q;
                        line_we_c   = 1'b1;
                        dirty_set_c = 1'b1;
                    end else begin
                        data_o_d = cur_line_c[{req_off_c, 5'd0} +: WORD_BITS];
                    end
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (valid_q[req_idx_c] && dirty_q[req_idx_c]) begin
                    ctrl_addr_d = {cur_tag_c, req_idx_c, 2'b00};
                    ctrl_data_d = cur_line_c;
                    ctrl_we_d   = 1'b1;
                    state_d     = WB;
                end else begin
                    ctrl_addr_d = {req_addr_q[31:5], 2'b00};
                    ctrl_rd_d   = 1'b1;
                    state_d     = FILL;
                end
            end
            WB: begin
                if (ctrl_ack_o) begin
                    dirty_clr_c = 1'b1;
                    state_d     = WB_REL;
                end else begin
                    ctrl_we_d = 1'b1;
                end
            end
            WB_REL: begin
                if (!ctrl_ack_o) begin
                    ctrl_addr_d = {req_addr_q[31:5], 2'b00};
                    ctrl_rd_d   = 1'b1;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (ctrl_ack_o) begin
                    line_wdata_c = ctrl_data_o;
                    line_we_c    = 1'b1;
                    tag_we_c     = 1'b1;
                    valid_set_c  = 1'b1;
                    dirty_clr_c  = 1'b1;
                    state_d      = FILL_REL;
                end else begin
                    ctrl_rd_d = 1'b1;
                end
            end
            FILL_REL: begin
                if (!ctrl_ack_o) begin
                    state_d = COMPARE;
                end
            end
            DONE: begin
                if (!we_i && !rd_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            init_seen_q <= 1'b0;
            ack_o       <= 1'b0;
            data_o      <= '0;
            ctrl_addr_i <= '0;
            ctrl_data_i <= '0;
            ctrl_we_i   <= 1'b0;
            ctrl_rd_i   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_seen_q <= init_seen_d;
            ack_o       <= ack_d;
            data_o      <= data_o_d;
            ctrl_addr_i <= ctrl_addr_d;
            ctrl_data_i <= ctrl_data_d;
            ctrl_we_i   <= ctrl_we_d;
            ctrl_rd_i   <= ctrl_rd_d;
        end
    end

    // Request latch; write wins when both levels are high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr_q <= '0;
            req_data_q <= '0;
            req_we_q   <= 1'b0;
        end else if (latch_c) begin
            req_addr_q <= addr_i[31:2];
            req_data_q <= data_i;
            req_we_q   <= we_i;
        end
    end

    // Valid and dirty flags per line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (valid_set_c) begin
                valid_q[req_idx_c] <= 1'b1;
            end
            if (dirty_set_c) begin
                dirty_q[req_idx_c] <= 1'b1;
            end else if (dirty_clr_c) begin
                dirty_q[req_idx_c] <= 1'b0;
            end
        end
    end

    // Line data and tag arrays; contents are qualified by valid, so no reset
    always_ff @(posedge clk) begin
        if (line_we_c) begin
            line_mem[req_idx_c] <= line_wdata_c;
        end
        if (tag_we_c) begin
            tag_mem[req_idx_c] <= req_tag_c;
        end
    end

endmodule

// File: tb/tb_ddr3_cache_ctrl.sv
// Directed bench for ddr3_cache_ctrl with a small scripted DDR responder.
module tb_ddr3_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_i;
    logic [31:0]  data_i;
    logic [31:0]  data_o;
    logic         we_i;
    logic         rd_i;
    logic         ack_o;
    logic [28:0]  ctrl_addr_i;
    logic [255:0] ctrl_data_i;
    logic [255:0] ctrl_data_o;
    logic         ctrl_we_i;
    logic         ctrl_rd_i;
    logic         ctrl_ack_o;
    logic [15:0]  state_value;

    ddr3_cache_ctrl #(.INDEX_BITS(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .we_i        (we_i),
        .rd_i        (rd_i),
        .ack_o       (ack_o),
        .ctrl_addr_i (ctrl_addr_i),
        .ctrl_data_i (ctrl_data_i),
        .ctrl_data_o (ctrl_data_o),
        .ctrl_we_i   (ctrl_we_i),
        .ctrl_rd_i   (ctrl_rd_i),
        .ctrl_ack_o  (ctrl_ack_o),
        .state_value (state_value)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // DDR responder state and command log
    bit           ddr_auto  = 1'b0;
    bit           pulse_req = 1'b0;
    logic [255:0] fill_line = '0;
    int           wb_cnt = 0, rd_cnt = 0, overlap_cnt = 0;
    int           cmd_seq = 0, wb_seq = 0, rd_seq = 0;
    logic [28:0]  wb_addr = '0, rd_addr = '0;
    logic [255:0] wb_data = '0;

    // Answers each strobe after two cycles with a two-cycle ack; also emits the init pulse
    initial begin : ddr_model
        ctrl_ack_o  = 1'b0;
        ctrl_data_o = '0;
        forever begin
            @(posedge clk); #2;
            if (pulse_req) begin
                ctrl_ack_o = 1'b1;
                @(posedge clk); #2;
                ctrl_ack_o = 1'b0;
                pulse_req  = 1'b0;
            end else if (ddr_auto && (ctrl_we_i || ctrl_rd_i)) begin
                cmd_seq++;
                if (ctrl_we_i) begin
                    wb_cnt++; wb_seq = cmd_seq; wb_addr = ctrl_addr_i; wb_data = ctrl_data_i;
                end else begin
                    rd_cnt++; rd_seq = cmd_seq; rd_addr = ctrl_addr_i;
                end
                repeat (2) @(posedge clk);
                #2;
                ctrl_data_o = fill_line;
                ctrl_ack_o  = 1'b1;
                repeat (2) @(posedge clk);
                #2;
                ctrl_ack_o = 1'b0;
            end
        end
    end

    // Both strobes high at once is never legal
    always @(negedge clk) begin
        if (rst && ctrl_we_i && ctrl_rd_i) overlap_cnt++;
    end

    // One bus transaction, entered and left at posedge+1
    task automatic bus_req(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                           output int lat, output int acks, output logic [31:0] rdata, output logic [15:0] st);
        addr_i = a; data_i = d; we_i = w; rd_i = !w;
        lat = 0; acks = 0; rdata = '0; st = '0;
        while (acks == 0 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (ack_o) begin
                acks  = 1;
                rdata = data_o;
                st    = state_value;
            end
        end
        repeat (hold) begin
            @(posedge clk); #1;
            if (ack_o) acks++;
        end
        we_i = 1'b0; rd_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack_o) acks++;
        end
    endtask

    int          lat, acks, rd0, wb0, n;
    logic [31:0] rdata;
    logic [15:0] st;
    bit          saw;

    initial begin
        rst = 1'b0; addr_i = '0; data_i = '0; we_i = 1'b0; rd_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack_o, 0);
        check("rst_state", state_value, 0);
        check("rst_strobes", {ctrl_we_i, ctrl_rd_i}, 0);
        check("rst_data_o", data_o, 0);
        check("rst_ctrl_addr", ctrl_addr_i, 0);
        check("rst_ctrl_data", ctrl_data_i, 0);

        // Requests during calibration are not acknowledged
        rst = 1'b1;
        addr_i = 32'h0; data_i = 32'h0123_4567; we_i = 1'b1;
        acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack_o) acks++;
        end
        check("init_no_ack", acks, 0);
        check("init_state", state_value, 0);
        we_i = 1'b0;

        pulse_req = 1'b1;
        @(posedge clk); #1;
        check("init_ack_high_state", state_value, 0);
        @(posedge clk); #1;
        check("init_done_state", state_value, 1);
        ddr_auto = 1'b1;

        // Write miss into an empty cache: fill only
        fill_line = '0;
        bus_req(1'b1, 32'h0000_0000, 32'h0123_4567, 0, lat, acks, rdata, st);
        check("w0_acks", acks, 1);
        check("w0_state_at_ack", st, 7);
        check("w0_rd_cnt", rd_cnt, 1);
        check("w0_wb_cnt", wb_cnt, 0);
        check("w0_rd_addr", rd_addr, 0);

        // Read hit
        rd0 = rd_cnt; wb0 = wb_cnt;
        bus_req(1'b0, 32'h0000_0000, 32'h0, 0, lat, acks, rdata, st);
        check("r0_lat", lat, 2);
        check("r0_data", rdata, 32'h0123_4567);
        check("r0_acks", acks, 1);
        check("r0_no_ddr", (rd_cnt - rd0) + (wb_cnt - wb0), 0);

        // Write hit then read hit on word 1
        bus_req(1'b1, 32'h0000_0004, 32'h0102_0304, 0, lat, acks, rdata, st);
        check("w4_lat", lat, 2);
        bus_req(1'b0, 32'h0000_0004, 32'h0, 0, lat, acks, rdata, st);
        check("r4_lat", lat, 2);
        check("r4_data", rdata, 32'h0102_0304);
        check("r4_no_ddr", (rd_cnt - rd0) + (wb_cnt - wb0), 0);

        // Conflict miss with dirty victim: writeback then fill
        bus_req(1'b0, 32'h0010_0000, 32'h0, 0, lat, acks, rdata, st);
        check("cm_acks", acks, 1);
        check("cm_wb_cnt", wb_cnt - wb0, 1);
        check("cm_rd_cnt", rd_cnt - rd0, 1);
        check("cm_wb_addr", wb_addr, 0);
        check("cm_wb_data", wb_data, {192'd0, 32'h0102_0304, 32'h0123_4567});
        check("cm_order", (wb_seq < rd_seq), 1);
        check("cm_rd_addr", rd_addr, 29'h002_0000);
        check("cm_data", rdata, 0);

        // Clean victim: fill only, word 3 of a patterned line
        for (int w = 0; w < 8; w++) fill_line[w*32 +: 32] = 32'h1111_1111 * (w + 1);
        rd0 = rd_cnt; wb0 = wb_cnt;
        bus_req(1'b0, 32'h0000_000C, 32'h0, 0, lat, acks, rdata, st);
        check("cv_wb_cnt", wb_cnt - wb0, 0);
        check("cv_rd_cnt", rd_cnt - rd0, 1);
        check("cv_rd_addr", rd_addr, 0);
        check("cv_data", rdata, 32'h4444_4444);

        // Request held for three cycles after ack: one ack only
        bus_req(1'b0, 32'h0000_000C, 32'h0, 3, lat, acks, rdata, st);
        check("hold_acks", acks, 1);
        check("hold_data", rdata, 32'h4444_4444);

        // Last index, last word
        bus_req(1'b1, 32'h0000_07FC, 32'hDEAD_BEEF, 0, lat, acks, rdata, st);
        check("top_w_acks", acks, 1);
        check("top_rd_addr", rd_addr, 29'h0FC);
        bus_req(1'b0, 32'h0000_07FC, 32'h0, 0, lat, acks, rdata, st);
        check("top_r7_lat", lat, 2);
        check("top_r7_data", rdata, 32'hDEAD_BEEF);
        bus_req(1'b0, 32'h0000_07E0, 32'h0, 0, lat, acks, rdata, st);
        check("top_r0_data", rdata, 32'h1111_1111);
        check("data_o_held", data_o, 32'h1111_1111);
        check("no_overlap", overlap_cnt, 0);

        // Reset while a fill is outstanding
        ddr_auto = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        addr_i = 32'h0000_0040; rd_i = 1'b1;
        saw = 1'b0; n = 0;
        while (!saw && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ctrl_rd_i) saw = 1'b1;
        end
        check("rf_rd_seen", saw, 1);
        check("rf_rd_addr", ctrl_addr_i, 29'h008);
        #2 rst = 1'b0;
        #1;
        check("rf_rd_dropped", ctrl_rd_i, 0);
        check("rf_state", state_value, 0);
        rd_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rf_stays_init", state_value, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
